// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and constants for the minterm sweeper.
// Holds the FSM state encoding, the default geometry (inputs, outputs,
// settle time) and the golden minterm masks of Out_1/Out_2/Out_3.
package sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_N_OUT  = 3;
  localparam int DEF_SETTLE = 1;

  // settle counter width, enough for SETTLE up to 15
  localparam int CNT_W = 4;

  localparam logic [15:0] MASK_OUT1 = 16'h2202;
  localparam logic [15:0] MASK_OUT2 = 16'hE0E6;
  localparam logic [15:0] MASK_OUT3 = 16'hAC8C;

endpackage

// File: rtl/sweep_capture.sv
// sweep_capture: N_OUT x 2^N_IN minterm mask bank.
// Cleared on reset or sweep acceptance, one bit per output written per
// sample, read through a mask_sel mux (out-of-range selects read 0).
// Optional comparator enabled by MINTERM_SWEEPER_CHECK_EN.
module sweep_capture
  import sweep_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic                         i_wr,
  input  logic                         i_cmp,
  input  logic [N_IN-1:0]              i_idx,
  input  logic [N_OUT-1:0]             i_resp,
  input  logic [1:0]                   i_sel,
  input  logic [N_OUT*(1<<N_IN)-1:0]   i_exp_mask,
  output logic [(1<<N_IN)-1:0]         o_mask,
  output logic [N_OUT-1:0]             o_mismatch
);

  localparam int MASK_W = 1 << N_IN;

  logic [N_OUT-1:0][MASK_W-1:0] r_mask;

  // clear on reset/accept, otherwise capture one minterm bit per output
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_mask <= '0;
    end else if (i_wr) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_mask[j][i_idx] <= i_resp[j];
      end
    end
  end

  // combinational read port, unused selects return zero
  always_comb begin
    o_mask = '0;
    if (int'(i_sel) < N_OUT) begin
      o_mask = r_mask[i_sel];
    end
  end

`ifdef MINTERM_SWEEPER_CHECK_EN
  logic [N_OUT-1:0]             r_mismatch;
  logic [N_OUT-1:0][MASK_W-1:0] w_mask_fin;

  // the compare fires on the final sample edge, so fold in that last bit
  always_comb begin
    w_mask_fin = r_mask;
    for (int j = 0; j < N_OUT; j++) begin
      w_mask_fin[j][i_idx] = i_resp[j];
    end
  end

  // latch per-output compare result when the sweep enters DONE
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_mismatch <= '0;
    end else if (i_cmp) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_mismatch[j] <= (w_mask_fin[j] != i_exp_mask[j*MASK_W +: MASK_W]);
      end
    end
  end

  assign o_mismatch = r_mismatch;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{i_exp_mask, i_cmp};
  assign o_mismatch   = '0;
`endif

endmodule

// File: rtl/minterm_sweeper.sv
// minterm_sweeper: self-timed truth-table sweep of a small combinational
// circuit. Drives stim = 0..2^N_IN-1 (A is the MSB), holds each value for
// SETTLE cycles and captures every circuit output into a minterm mask.
// Optional expected-mask comparator: define MINTERM_SWEEPER_CHECK_EN.
//
//   state    | meaning
//   S_IDLE   | waiting for start, masks hold last sweep
//   S_WAIT   | stim applied, settle counter running
//   S_SAMPLE | capture resp into masks, advance or finish
//   S_DONE   | one-cycle done pulse, back to idle
module minterm_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  output logic [N_IN-1:0]              o_stim,
  input  logic [N_OUT-1:0]             i_resp,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [1:0]                   i_mask_sel,
  output logic [(1<<N_IN)-1:0]         o_mask,
  input  logic [N_OUT*(1<<N_IN)-1:0]   i_exp_mask,
  output logic [N_OUT-1:0]             o_mismatch
);

  // WAIT lasts SETTLE cycles: load SETTLE-1 and leave on terminal count 0
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [N_IN-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_clr, w_wr, w_cmp;

  // state, index and settle-counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next-state logic and capture strobes
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_wr        = 1'b0;
    w_cmp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clr     = 1'b1;
          w_idx_nxt = '0;
          w_cnt_nxt = CNT_LOAD;
          w_state_nxt = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SAMPLE: begin
        w_wr = 1'b1;
        if (&r_idx) begin
          w_cmp       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_stim = r_idx;
  assign o_busy = (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign o_done = (r_state == S_DONE);

  sweep_capture #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_capture (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .i_wr       (w_wr),
    .i_cmp      (w_cmp),
    .i_idx      (r_idx),
    .i_resp     (i_resp),
    .i_sel      (i_mask_sel),
    .i_exp_mask (i_exp_mask),
    .o_mask     (o_mask),
    .o_mismatch (o_mismatch)
  );

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper: directed bench for minterm_sweeper.
// Two instances: default SETTLE=1 and SETTLE=0. The circuits Out_1/2/3 are
// modelled as truth-table lookups driven from each instance's stim.
module tb_minterm_sweeper;

  localparam logic [15:0] G1 = 16'h2202;
  localparam logic [15:0] G2 = 16'hE0E6;
  localparam logic [15:0] G3 = 16'hAC8C;

`ifdef MINTERM_SWEEPER_CHECK_EN
  localparam logic [2:0] EXP_MM = 3'b100;
`else
  localparam logic [2:0] EXP_MM = 3'b000;
`endif

  logic        clk;
  logic        rst;
  logic        start, start0;
  logic [3:0]  stim, stim0;
  logic [2:0]  resp, resp0;
  logic        busy, busy0, done, done0;
  logic [1:0]  mask_sel, mask_sel0;
  logic [15:0] mask, mask0;
  logic [47:0] exp_mask, exp_mask0;
  logic [2:0]  mismatch, mismatch0;
  logic [2:0][15:0] gold;

  int total = 0;
  int bad   = 0;
  int nd;

  minterm_sweeper u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_stim(stim), .i_resp(resp),
    .o_busy(busy), .o_done(done), .i_mask_sel(mask_sel), .o_mask(mask),
    .i_exp_mask(exp_mask), .o_mismatch(mismatch)
  );

  minterm_sweeper #(.SETTLE(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_stim(stim0), .i_resp(resp0),
    .o_busy(busy0), .o_done(done0), .i_mask_sel(mask_sel0), .o_mask(mask0),
    .i_exp_mask(exp_mask0), .o_mismatch(mismatch0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // circuit models: output j at stim k is bit k of its golden mask
  always_comb begin
    resp  = '0;
    resp0 = '0;
    for (int j = 0; j < 3; j++) begin
      resp[j]  = gold[j][stim];
      resp0[j] = gold[j][stim0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // read all four selects of one instance against the golden masks
  task automatic check_masks(input string tag, input bit which, input bit zero);
    logic [15:0] e;
    for (int s = 0; s < 4; s++) begin
      if (which) mask_sel0 = 2'(s); else mask_sel = 2'(s);
      #1;
      case (s)
        0: e = G1;
        1: e = G2;
        2: e = G3;
        default: e = 16'h0;
      endcase
      if (zero) e = 16'h0;
      chk($sformatf("%s_sel%0d", tag, s), which ? mask0 : mask, e);
    end
    mask_sel  = 2'd0;
    mask_sel0 = 2'd0;
  endtask

  // one sweep on the SETTLE=1 instance; start re-pulsed at cycles pa/pb
  task automatic sweep(input int pa, input int pb, output int n_done);
    mask_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_stim", stim, 0);
    chk("accept_clear", mask, 0);
    chk("accept_mm", mismatch, 0);
    n_done = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == pa || n == pb) start = 1'b1;
      tick();
      start = 1'b0;
      if (done) begin
        n_done = n;
        break;
      end
      chk($sformatf("stim_c%0d", n), stim, n / 2);
      chk($sformatf("busy_c%0d", n), busy, 1);
    end
    chk("done_cycle", n_done, 32);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    gold      = {G3, G2, G1};
    rst       = 1'b1;
    start     = 1'b0;
    start0    = 1'b0;
    mask_sel  = 2'd0;
    mask_sel0 = 2'd0;
    exp_mask  = {16'hAC8D, G2, G1};
    exp_mask0 = {G3, G2, G1};
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mm", mismatch, 0);
    check_masks("rst_mask", 1'b0, 1'b1);

    // default sweep
    sweep(0, 0, nd);
    check_masks("sweep1", 1'b0, 1'b0);
    chk("sweep1_mm", mismatch, EXP_MM);
    tick();
    chk("done_fall", done, 0);
    chk("idle_busy", busy, 0);

    // back-to-back: start sampled on the first edge after returning to IDLE
    sweep(0, 0, nd);
    check_masks("b2b", 1'b0, 1'b0);
    chk("b2b_mm", mismatch, EXP_MM);
    tick();

    // start pulses while busy are ignored
    sweep(5, 20, nd);
    check_masks("busy_start", 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("no_requeue_busy", busy, 0);
    chk("no_requeue_done", done, 0);

    // reset mid-sweep at cycle 12
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 12; n++) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_stim", stim, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mm", mismatch, 0);
    check_masks("midrst_mask", 1'b0, 1'b1);
    sweep(0, 0, nd);
    check_masks("post_rst", 1'b0, 1'b0);
    chk("post_rst_mm", mismatch, EXP_MM);

    // SETTLE=0 instance: one stim step per cycle, done at E0+16
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("s0_accept_stim", stim0, 0);
    chk("s0_accept_busy", busy0, 1);
    nd = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done0) begin
        nd = n;
        break;
      end
      chk($sformatf("s0_stim_c%0d", n), stim0, n);
    end
    chk("s0_done_cycle", nd, 16);
    chk("s0_done_busy", busy0, 0);
    check_masks("s0", 1'b1, 1'b0);
    chk("s0_mm", mismatch0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
